// File: rtl/sct_seq_counter_if.sv
// sct_seq_counter_if: control/status bundle between a sequencer and
// sct_seq_counter.
//   en       global enable (sequencer -> counter)
//   load     load request; aborts any run
//   load_val value captured on load, WIDTH bits
//   start    run request, honoured only when idle and enabled
//   up       direction sampled with start (1 = increment)
//   cnt      registered counter value (counter -> sequencer)
//   zero     cnt == 0, combinational from cnt
//   busy     registered, counter is running
//   done     registered one-cycle completion pulse
interface sct_seq_counter_if #(
  parameter int WIDTH = 8
) ();
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             up;
  logic [WIDTH-1:0] cnt;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output en, load, load_val, start, up,
    input  cnt, zero, busy, done
  );

  modport slave (
    input  en, load, load_val, start, up,
    output cnt, zero, busy, done
  );
endinterface

// File: rtl/sct_seq_counter.sv
// sct_seq_counter: WIDTH-bit loadable up/down counter with an IDLE/RUN/DONE
// run controller, global enable and terminal-count detection. With WRAP=1
// the counter reloads from the reload register at terminal count and keeps
// running, which makes it a periodic timer.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  sct_seq_counter_if slave modport (en, load, load_val, start, up in;
//        cnt, zero, busy, done out)
module sct_seq_counter #(
  parameter int WIDTH = 8,
  parameter int WRAP  = 0
) (
  input logic              clk,
  input logic              rst,
  sct_seq_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] term;

  // Terminal value follows the direction captured at start.
  always_comb begin
    if (dir_q) begin
      term = CNT_MAX;
    end else begin
      term = CNT_ZERO;
    end
  end

  // Next-state logic: load beats start beats counting; done defaults low so
  // it can only ever be a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    if (bus.load) begin
      cnt_d    = bus.load_val;
      reload_d = bus.load_val;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // cnt is left untouched on the accepting edge
          if (bus.start && bus.en) begin
            dir_d   = bus.up;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.en) begin
            if (cnt_q == term) begin
              done_d = 1'b1;
              if (WRAP != 0) begin
                cnt_d   = reload_q;
                state_d = ST_RUN;
              end else begin
                state_d = ST_DONE;
              end
            end else if (dir_q) begin
              cnt_d = cnt_q + CNT_ONE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          // start is deliberately ignored here
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // busy is registered from the next state so it tracks state == RUN
    busy_d = (state_d == ST_RUN);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.zero = (cnt_q == CNT_ZERO);
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_sct_seq_counter.sv
// Directed bench for sct_seq_counter: three instances cover WIDTH=8 one-shot,
// WIDTH=4 one-shot and WIDTH=8 auto-reload.
module tb_sct_seq_counter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sct_seq_counter_if #(.WIDTH(8)) if8 ();
  sct_seq_counter_if #(.WIDTH(4)) if4 ();
  sct_seq_counter_if #(.WIDTH(8)) ifw ();

  sct_seq_counter #(.WIDTH(8), .WRAP(0)) u_d8 (.clk(clk), .rst(rst), .bus(if8));
  sct_seq_counter #(.WIDTH(4), .WRAP(0)) u_d4 (.clk(clk), .rst(rst), .bus(if4));
  sct_seq_counter #(.WIDTH(8), .WRAP(1)) u_dw (.clk(clk), .rst(rst), .bus(ifw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge; inputs change and outputs are sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (if8.cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", if8.cnt); end
    checks++; if (if8.zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%0b exp=1", if8.zero); end
    checks++; if (if8.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", if8.busy); end
    checks++; if (if8.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", if8.done); end
    checks++; if (ifw.cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt_w got=%0d exp=0", ifw.cnt); end
  endtask

  // load 3, count down: 3,2,1,0 then done with busy low, then IDLE
  task automatic test_count_down();
    logic [7:0] exp_cnt [4];
    logic       exp_done [4];
    logic       exp_busy [4];
    logic       exp_zero [4];
    exp_cnt  = '{8'd2, 8'd1, 8'd0, 8'd0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_zero = '{1'b0, 1'b0, 1'b1, 1'b1};
    if8.en = 1'b1; if8.load = 1'b1; if8.load_val = 8'd3;
    tick();
    if8.load = 1'b0; if8.start = 1'b1; if8.up = 1'b0;
    checks++; if (if8.cnt !== 8'd3) begin failures++; $display("FAIL dn_load got=%0d exp=3", if8.cnt); end
    tick();
    if8.start = 1'b0;
    checks++; if (if8.cnt !== 8'd3 || if8.busy !== 1'b1) begin failures++; $display("FAIL dn_start cnt=%0d busy=%0b exp cnt=3 busy=1", if8.cnt, if8.busy); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (if8.cnt !== exp_cnt[k] || if8.done !== exp_done[k] || if8.busy !== exp_busy[k] || if8.zero !== exp_zero[k]) begin
        failures++;
        $display("FAIL dn_edge%0d cnt=%0d done=%0b busy=%0b zero=%0b exp cnt=%0d done=%0b busy=%0b zero=%0b",
                 k, if8.cnt, if8.done, if8.busy, if8.zero, exp_cnt[k], exp_done[k], exp_busy[k], exp_zero[k]);
      end
    end
    tick();
    checks++; if (if8.done !== 1'b0 || if8.busy !== 1'b0 || if8.cnt !== 8'd0) begin failures++; $display("FAIL dn_idle cnt=%0d done=%0b busy=%0b exp 0/0/0", if8.cnt, if8.done, if8.busy); end
  endtask

  // WIDTH=4 count up from 13: stops at 15, never wraps to 0
  task automatic test_count_up_w4();
    logic [3:0] exp_cnt [6];
    logic       exp_done [6];
    logic       exp_busy [6];
    exp_cnt  = '{4'd14, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_busy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    if4.en = 1'b1; if4.load = 1'b1; if4.load_val = 4'd13;
    tick();
    if4.load = 1'b0; if4.start = 1'b1; if4.up = 1'b1;
    tick();
    if4.start = 1'b0;
    checks++; if (if4.cnt !== 4'd13 || if4.busy !== 1'b1) begin failures++; $display("FAIL up_start cnt=%0d busy=%0b exp cnt=13 busy=1", if4.cnt, if4.busy); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (if4.cnt !== exp_cnt[k] || if4.done !== exp_done[k] || if4.busy !== exp_busy[k]) begin
        failures++;
        $display("FAIL up_edge%0d cnt=%0d done=%0b busy=%0b exp cnt=%0d done=%0b busy=%0b",
                 k, if4.cnt, if4.done, if4.busy, exp_cnt[k], exp_done[k], exp_busy[k]);
      end
    end
  endtask

  // WRAP=1: load 2, count down: 1,0,2(done),1,0,2(done),1 with busy held
  task automatic test_wrap();
    logic [7:0] exp_cnt [7];
    logic       exp_done [7];
    exp_cnt  = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    ifw.en = 1'b1; ifw.load = 1'b1; ifw.load_val = 8'd2;
    tick();
    ifw.load = 1'b0; ifw.start = 1'b1; ifw.up = 1'b0;
    tick();
    ifw.start = 1'b0;
    checks++; if (ifw.cnt !== 8'd2 || ifw.busy !== 1'b1) begin failures++; $display("FAIL wrap_start cnt=%0d busy=%0b exp cnt=2 busy=1", ifw.cnt, ifw.busy); end
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (ifw.cnt !== exp_cnt[k] || ifw.done !== exp_done[k] || ifw.busy !== 1'b1) begin
        failures++;
        $display("FAIL wrap_edge%0d cnt=%0d done=%0b busy=%0b exp cnt=%0d done=%0b busy=1",
                 k, ifw.cnt, ifw.done, ifw.busy, exp_cnt[k], exp_done[k]);
      end
    end
    ifw.load = 1'b1; ifw.load_val = 8'd0;
    tick();
    ifw.load = 1'b0;
    checks++; if (ifw.busy !== 1'b0 || ifw.done !== 1'b0) begin failures++; $display("FAIL wrap_stop busy=%0b done=%0b exp 0/0", ifw.busy, ifw.done); end
  endtask

  // en pattern 1,0,0,1,... from 5 down: two hold cycles, done two edges late
  task automatic test_enable();
    logic       en_pat  [8];
    logic [7:0] exp_cnt [8];
    logic       exp_done [8];
    en_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_cnt  = '{8'd4, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    if8.en = 1'b1; if8.load = 1'b1; if8.load_val = 8'd5;
    tick();
    if8.load = 1'b0; if8.start = 1'b1; if8.up = 1'b0;
    tick();
    if8.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if8.en = en_pat[k];
      tick();
      checks++;
      if (if8.cnt !== exp_cnt[k] || if8.done !== exp_done[k] || if8.busy !== (k < 7)) begin
        failures++;
        $display("FAIL en_edge%0d cnt=%0d done=%0b busy=%0b exp cnt=%0d done=%0b busy=%0b",
                 k, if8.cnt, if8.done, if8.busy, exp_cnt[k], exp_done[k], (k < 7));
      end
    end
    // load acts even with en low
    tick();
    if8.en = 1'b0; if8.load = 1'b1; if8.load_val = 8'd7;
    tick();
    if8.load = 1'b0; if8.en = 1'b1;
    checks++; if (if8.cnt !== 8'd7) begin failures++; $display("FAIL en_load got=%0d exp=7", if8.cnt); end
  endtask

  // load with simultaneous start mid-run aborts; the start is ignored
  task automatic test_abort_load();
    if8.en = 1'b1; if8.load = 1'b1; if8.load_val = 8'd200;
    tick();
    if8.load = 1'b0; if8.start = 1'b1; if8.up = 1'b0;
    tick();
    if8.start = 1'b0;
    tick();
    tick();
    checks++; if (if8.cnt !== 8'd198 || if8.busy !== 1'b1) begin failures++; $display("FAIL abl_run cnt=%0d busy=%0b exp cnt=198 busy=1", if8.cnt, if8.busy); end
    if8.load = 1'b1; if8.load_val = 8'd9; if8.start = 1'b1;
    tick();
    if8.load = 1'b0; if8.start = 1'b0;
    checks++; if (if8.cnt !== 8'd9 || if8.busy !== 1'b0 || if8.done !== 1'b0) begin failures++; $display("FAIL abl_abort cnt=%0d busy=%0b done=%0b exp 9/0/0", if8.cnt, if8.busy, if8.done); end
    tick();
    checks++; if (if8.cnt !== 8'd9 || if8.busy !== 1'b0) begin failures++; $display("FAIL abl_hold cnt=%0d busy=%0b exp 9/0", if8.cnt, if8.busy); end
  endtask

  // synchronous reset mid-run
  task automatic test_abort_rst();
    if8.en = 1'b1; if8.load = 1'b1; if8.load_val = 8'd50;
    tick();
    if8.load = 1'b0; if8.start = 1'b1; if8.up = 1'b0;
    tick();
    if8.start = 1'b0;
    tick();
    tick();
    checks++; if (if8.cnt !== 8'd48 || if8.zero !== 1'b0 || if8.busy !== 1'b1) begin failures++; $display("FAIL abr_run cnt=%0d zero=%0b busy=%0b exp 48/0/1", if8.cnt, if8.zero, if8.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (if8.cnt !== 8'd0 || if8.zero !== 1'b1 || if8.busy !== 1'b0 || if8.done !== 1'b0) begin failures++; $display("FAIL abr_rst cnt=%0d zero=%0b busy=%0b done=%0b exp 0/1/0/0", if8.cnt, if8.zero, if8.busy, if8.done); end
  endtask

  // start at terminal, start in DONE ignored, then back-to-back restart
  task automatic test_back_to_back();
    if8.en = 1'b1; if8.load = 1'b1; if8.load_val = 8'd0;
    tick();
    if8.load = 1'b0; if8.start = 1'b1; if8.up = 1'b0;
    tick();
    if8.start = 1'b0;
    checks++; if (if8.busy !== 1'b1 || if8.done !== 1'b0) begin failures++; $display("FAIL b2b_start busy=%0b done=%0b exp 1/0", if8.busy, if8.done); end
    tick();
    checks++; if (if8.done !== 1'b1 || if8.busy !== 1'b0 || if8.cnt !== 8'd0) begin failures++; $display("FAIL b2b_term done=%0b busy=%0b cnt=%0d exp 1/0/0", if8.done, if8.busy, if8.cnt); end
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    checks++; if (if8.done !== 1'b0 || if8.busy !== 1'b0) begin failures++; $display("FAIL b2b_ign1 done=%0b busy=%0b exp 0/0", if8.done, if8.busy); end
    tick();
    checks++; if (if8.done !== 1'b0 || if8.busy !== 1'b0) begin failures++; $display("FAIL b2b_ign2 done=%0b busy=%0b exp 0/0", if8.done, if8.busy); end
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    checks++; if (if8.busy !== 1'b1) begin failures++; $display("FAIL b2b_restart busy=%0b exp 1", if8.busy); end
    tick();
    checks++; if (if8.done !== 1'b1 || if8.busy !== 1'b0) begin failures++; $display("FAIL b2b_redone done=%0b busy=%0b exp 1/0", if8.done, if8.busy); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    if8.en = 1'b0; if8.load = 1'b0; if8.load_val = 8'd0; if8.start = 1'b0; if8.up = 1'b0;
    if4.en = 1'b0; if4.load = 1'b0; if4.load_val = 4'd0; if4.start = 1'b0; if4.up = 1'b0;
    ifw.en = 1'b0; ifw.load = 1'b0; ifw.load_val = 8'd0; ifw.start = 1'b0; ifw.up = 1'b0;
    test_reset();
    test_count_down();
    test_count_up_w4();
    test_wrap();
    test_enable();
    test_abort_load();
    test_abort_rst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sct_seq_counter.md
# sct_seq_counter

Parametrised sequential successor to the combinational `sct` counter-step controller. It replaces the external state chain with an internal WIDTH-bit loadable up/down counter, a 3-state run controller, a global enable and terminal-count detection. An optional auto-reload (wrap) mode turns it into a periodic timer. It sits in the control path and drives `done` and `busy` to the downstream sequencer.

## Interface

Parameters:

- `WIDTH`, 8: counter width in bits; minimum 2.
- `WRAP`, 0: 0 = one-shot, stop at terminal count; 1 = auto-reload from the reload register and keep running.

Ports:

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global enable; when 0, counter and FSM hold (load and reset still act).
- `load`  in  1  load `load_val` into the counter and the reload register; abort any run.
- `load_val`  in  WIDTH  value captured on `load`.
- `start`  in  1  begin a run from the current counter value; honoured only in IDLE with `en`=1.
- `up`  in  1  direction, sampled with `start`: 1 = increment, 0 = decrement.
- `cnt`  out  WIDTH  registered counter value.
- `zero`  out  1  combinational, `cnt` == 0.
- `busy`  out  1  registered, state == RUN.
- `done`  out  1  registered one-cycle completion pulse.

## Operation

- States are IDLE, RUN and DONE. Registers are `cnt`, `reload`, `dir` and `done`.
- Terminal value `term` is 0 when `dir`=0 and 2^WIDTH−1 when `dir`=1.
- Priority per edge, highest first: `rst` > `load` > `start` > count.
- `rst`:
  - cnt=0, reload=0, dir=0, state=IDLE, done=0.
  - Applies from any state, including mid-run.
- `load` (any state, independent of `en`):
  - cnt and reload take `load_val`; state goes to IDLE; done=0.
  - A simultaneous `start` is ignored.
- IDLE:
  - `start` & `en` captures dir←`up` and moves to RUN.
  - `cnt` is unchanged on that edge.
- RUN with `en`=1:
  - If cnt ≠ term: cnt ← cnt+1 when dir=1, cnt−1 when dir=0, modulo 2^WIDTH.
  - If cnt == term and WRAP=0: state goes to DONE, cnt holds, done←1.
  - If cnt == term and WRAP=1: cnt ← reload, state stays RUN, done←1.
- RUN with `en`=0: everything holds; done←0.
- DONE: unconditionally goes to IDLE on the next edge; done←0. `start` in DONE is ignored.
- `start` in RUN or DONE is ignored; direction cannot change mid-run.
- Starting with cnt already at term completes on the first enabled RUN edge.
- WRAP=1 with reload == term pulses `done` on every enabled RUN edge.

## Timing

- Reset values: cnt=0, zero=1, busy=0, done=0.
- `start` accepted at edge E0: busy=1 from the cycle after E0.
- From start value S, completion occurs at the (|S−term|+1)-th enabled RUN edge after E0. `done` is high for exactly the following cycle.
- WRAP=0: busy drops in the same cycle done rises (state DONE). IDLE is reached one cycle later, so the earliest re-start edge is 2 cycles after the completing edge.
- WRAP=1: busy stays 1. The period between done pulses is |reload−term|+1 enabled cycles.
- `en` low cycles stretch the run one-for-one; no counts are lost or duplicated.
- `load` takes effect on the same edge: `cnt` shows `load_val` the next cycle, busy=0.
- No combinational path from inputs to outputs except `cnt`→`zero`.

## Test plan

- WIDTH=8, WRAP=0: load 3, start up=0, en=1 → cnt 3,2,1,0 on successive cycles. done=1 exactly one cycle after the 4th RUN edge; busy=0 from that cycle; IDLE the next cycle.
- WIDTH=4, up=1, load 13, WRAP=0 → cnt 13,14,15, then done pulse; cnt stays 15 and never wraps to 0.
- WRAP=1, WIDTH=8: load 2, start down → done pulses every 3 cycles. cnt sequence is 2,1,0,2,1,0…; busy is held 1.
- `en` toggled 1,0,0,1 during a run from 5 down → cnt holds for 2 cycles; done arrives 2 cycles later than with en held at 1.
- Mid-run abort:
  - `load`=1 with `load_val`=9 and `start`=1 on the same edge while in RUN → next cycle cnt=9, busy=0, done=0.
  - `rst` mid-run → cnt=0, zero=1, busy=0.
- Start at terminal: load 0, start down → done after 1 enabled RUN edge. `start` pulsed in DONE is ignored, and no second run begins.
